// File: rtl/ifu_inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer of {inst, addr, pred}
// entries, registered output (no bypass), with flush and synchronous reset.
module ifu_inst_queue #(
  parameter  int DEPTH  = 4,
  parameter  int INST_W = 32,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_flag_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              is_pred_branch_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              is_pred_branch_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [31:0]       INST_NOP  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic              pred;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_ready_o  = count < CNT_W'(DEPTH);
  assign out_valid_o = count != '0;
  assign push        = in_valid_i && in_ready_o && !flush_flag_i;
  assign pop         = out_valid_o && out_ready_i && !flush_flag_i;
  assign count_o     = count;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_flag_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry data is not reset; only pointers and occupancy carry meaning.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= '{inst: inst_i, addr: inst_addr_i, pred: is_pred_branch_i};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    inst_o           = {(INST_W/32){INST_NOP}};
    inst_addr_o      = ZERO_WORD;
    is_pred_branch_o = 1'b0;
    if (out_valid_o) begin
      inst_o           = head.inst;
      inst_addr_o      = head.addr;
      is_pred_branch_o = head.pred;
    end
  end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Scoreboard bench for ifu_inst_queue: expected entries queued on push,
// compared against the head on pop, occupancy checked every cycle.
module tb_ifu_inst_queue;
  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_flag_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [INST_W-1:0] inst_i = '0;
  logic [ADDR_W-1:0] inst_addr_i = '0;
  logic              is_pred_branch_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              is_pred_branch_o;
  logic [CNT_W-1:0]  count_o;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  ifu_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush_flag_i(flush_flag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .is_pred_branch_i(is_pred_branch_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .is_pred_branch_o(is_pred_branch_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle starting from a falling edge; ends on the next falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] ad,
                      input logic pr, input logic rdy, input logic fl);
    bit push, pop;
    in_valid_i = v; inst_i = ins; inst_addr_i = ad; is_pred_branch_i = pr;
    out_ready_i = rdy; flush_flag_i = fl;
    #1;
    chk("in_ready", in_ready_o, q.size() < DEPTH);
    chk("out_valid", out_valid_o, q.size() != 0);
    if (q.size() == 0) begin
      chk("idle_inst", inst_o, 64'h13);
      chk("idle_addr", inst_addr_o, 64'h0);
      chk("idle_pred", is_pred_branch_o, 64'h0);
    end
    push = v && (q.size() < DEPTH) && !fl;
    pop  = rdy && (q.size() != 0) && !fl;
    if (pop) begin
      chk("pop_inst", inst_o, q[0].inst);
      chk("pop_addr", inst_addr_o, q[0].addr);
      chk("pop_pred", is_pred_branch_o, q[0].pred);
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{inst: ins, addr: ad, pred: pr});
    end
    @(negedge clk);
    chk("count", count_o, q.size());
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1; in_valid_i = v; out_ready_i = 1'b1; flush_flag_i = 1'b0;
    inst_i = 32'hdead_beef; inst_addr_i = 32'h1000;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_inst", inst_o, 64'h13);
    chk("rst_addr", inst_addr_o, 0);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1, base + i, 32'h8000_0000 + 4 * i, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(0);

    // single push then pop
    step(1, 32'h13, 32'h8000_0000, 0, 0, 0);
    chk("first_inst", inst_o, 64'h13);
    chk("first_addr", inst_addr_o, 64'h8000_0000);
    step(0, 0, 0, 0, 1, 0);

    // overfill: fifth push dropped, then drain in order
    push_n(5, 32'h100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // full with steady push/pop, pointers wrap
    push_n(4, 32'h200);
    for (int i = 0; i < 8; i++) step(1, 32'h300 + i, 32'h9000_0000 + 4 * i, i[0], 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // flush beats push and pop
    push_n(3, 32'h400);
    step(1, 32'h4ff, 32'h4ff0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // predicted-branch flag travels with its entry
    step(1, 32'h500, 32'h5000, 0, 0, 0);
    step(1, 32'h501, 32'h5004, 1, 0, 0);
    step(1, 32'h502, 32'h5008, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

    // reset while pushing at count 2
    push_n(2, 32'h600);
    do_reset(1);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ifu_inst_queue.md
IFU_INST_QUEUE -- requirements
Module: ifu_inst_queue

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 4, meaning the number of queue entries (power of two, minimum 2).
REQ-002 The module SHALL expose parameter INST_W, default 32, meaning the instruction width.
REQ-003 The module SHALL expose parameter ADDR_W, default 32, meaning the instruction address width.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  meaning: clock; all state changes on its rising edge.
REQ-006 rst  input  1  meaning: synchronous active-high reset.
REQ-007 flush_flag_i  input  1  meaning: pipeline flush; discards all entries and the current push.
REQ-008 in_valid_i  input  1  meaning: fetch offers an instruction.
REQ-009 in_ready_o  output  1  meaning: queue accepts an instruction this cycle.
REQ-010 inst_i  input  INST_W  meaning: instruction word.
REQ-011 inst_addr_i  input  ADDR_W  meaning: instruction address.
REQ-012 is_pred_branch_i  input  1  meaning: fetch predicted this instruction as a taken branch.
REQ-013 out_valid_o  output  1  meaning: head entry is valid for decode.
REQ-014 out_ready_i  input  1  meaning: decode consumes the head entry this cycle.
REQ-015 inst_o  output  INST_W  meaning: head instruction.
REQ-016 inst_addr_o  output  ADDR_W  meaning: head address.
REQ-017 is_pred_branch_o  output  1  meaning: head predicted-branch flag.
REQ-018 count_o  output  $clog2(DEPTH)+1  meaning: current occupancy.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries {inst, addr, pred}, with write and read pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-020 Push SHALL occur when in_valid_i && in_ready_o && !flush_flag_i; pop SHALL occur when out_valid_o && out_ready_i && !flush_flag_i.
REQ-021 in_ready_o SHALL equal (count_o < DEPTH) combinationally; no push-through-when-full, no dependence on out_ready_i.
REQ-022 out_valid_o SHALL equal (count_o != 0); no combinational bypass, so minimum in-to-out latency is 1 cycle.
REQ-023 When out_valid_o is 0, inst_o SHALL be {INST_W/32 copies of INST_NOP}, inst_addr_o SHALL be ZeroWord (zero), is_pred_branch_o SHALL be 0.
REQ-024 When out_valid_o is 1, outputs SHALL present the entry at the read pointer and remain stable until popped or flushed.
REQ-025 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers, including at count_o = DEPTH-1 and count_o = 1.
REQ-026 Push only SHALL increment count_o by 1; pop only SHALL decrement by 1; count_o SHALL never exceed DEPTH nor underflow.
REQ-027 flush_flag_i SHALL take priority over push and pop: next cycle count_o = 0, both pointers = 0, out_valid_o = 0; the push offered in the flush cycle is dropped.
REQ-028 in_valid_i SHALL be ignored while in_ready_o = 0; the offered data is not captured.
REQ-029 Entries SHALL be delivered in exact push order with inst, addr and pred flag kept together.

Reset
REQ-030 While rst is 1 at a clock edge, next state SHALL be: pointers 0, count_o 0, out_valid_o 0, in_ready_o 1, outputs per REQ-023.
REQ-031 Reset SHALL override flush, push and pop in the same cycle; mid-operation reset discards all entries.
REQ-032 Entry data storage need not be reset; only pointers and count are reset.

Verification
REQ-033 Reset then push 0x00000013@0x80000000 -> next cycle out_valid_o=1, inst_o=0x00000013, inst_addr_o=0x80000000, count_o=1.
REQ-034 DEPTH=4, out_ready_i=0, push 5 back-to-back -> in_ready_o=0 after 4th push, 5th dropped, count_o=4; drain returns the first 4 in order.
REQ-035 count_o=4, in_valid_i=1, out_ready_i=1 for 8 cycles -> one pop per cycle, pushes only when count_o<4, pointers wrap, order preserved.
REQ-036 count_o=3, flush_flag_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, inst_o=NOP, inst_addr_o=0.
REQ-037 Push with is_pred_branch_i=1 between two with 0 -> only the middle entry pops with is_pred_branch_o=1.
REQ-038 count_o=2, assert rst for one cycle while pushing -> next cycle count_o=0, out_valid_o=0, in_ready_o=1.
